// File: rtl/stream_mux_rr_pkg.sv
// stream_mux_rr_pkg
// Shared constants and helpers for the round-robin stream multiplexer.
//   MODE_FIXED / MODE_RR : values of the mux 'mode' input
//   clog2()              : ceil(log2(v)), minimum 1, usable in parameter defaults
package stream_mux_rr_pkg;

  localparam logic MODE_FIXED = 1'b0;
  localparam logic MODE_RR    = 1'b1;

  function automatic int clog2(input int v);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++)
      if ((1 << i) < v) r = i + 1;
    return (r < 1) ? 1 : r;
  endfunction

endpackage

// File: rtl/stream_mux_rr_arb.sv
// rr_arbiter
// Combinational round-robin search: first asserted req[] after ptr, wrapping
// modulo N.
//   req         : per-channel request
//   ptr         : last granted channel (search starts at ptr+1)
//   en          : search enable; no grant when low
//   grant       : granted channel index (meaningful only with grant_valid)
//   grant_valid : some channel was granted
module rr_arbiter #(
  parameter int N     = 4,
  parameter int SEL_W = 2
) (
  input  logic [N-1:0]     req,
  input  logic [SEL_W-1:0] ptr,
  input  logic             en,
  output logic [SEL_W-1:0] grant,
  output logic             grant_valid
);

  // Walk from the farthest candidate back to ptr+1 so the nearest requester
  // is the last (winning) assignment.
  always_comb begin
    grant       = '0;
    grant_valid = 1'b0;
    if (en) begin
      for (int k = N; k >= 1; k--) begin
        if (req[(int'(ptr) + k) % N]) begin
          grant       = SEL_W'((int'(ptr) + k) % N);
          grant_valid = 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/stream_mux_rr.sv
// stream_mux_rr
// N-input valid/ready stream mux with a single registered output stage.
// Channel chosen either by a fixed select or by a round-robin pointer.
//   clk, reset  : clock, synchronous active-high reset
//   mode        : 0 fixed select, 1 round-robin
//   sel         : channel index in fixed mode (values >= N never grant)
//   in_data     : packed channel words, channel i at [i*WIDTH +: WIDTH]
//   in_valid    : per-channel valid
//   in_ready    : per-channel ready (one-hot or zero)
//   out_data    : registered output word
//   out_chan    : registered source channel of out_data
//   out_valid   : output register holds a word
//   out_ready   : downstream accepts this cycle
module stream_mux_rr
  import stream_mux_rr_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int N     = 4,
  parameter int SEL_W = clog2(N)
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               mode,
  input  logic [SEL_W-1:0]   sel,
  input  logic [N*WIDTH-1:0] in_data,
  input  logic [N-1:0]       in_valid,
  output logic [N-1:0]       in_ready,
  output logic [WIDTH-1:0]   out_data,
  output logic [SEL_W-1:0]   out_chan,
  output logic               out_valid,
  input  logic               out_ready
);

  logic [SEL_W-1:0] ptr;
  logic [SEL_W-1:0] rr_grant;
  logic             rr_valid;
  logic             fix_ok;
  logic [SEL_W-1:0] grant;
  logic             gnt_v;
  logic             load_en;
  logic [WIDTH-1:0] sel_data;

  assign load_en = !out_valid || out_ready;

  rr_arbiter #(.N(N), .SEL_W(SEL_W)) u_arb (
    .req         (in_valid),
    .ptr         (ptr),
    .en          (mode == MODE_RR),
    .grant       (rr_grant),
    .grant_valid (rr_valid)
  );

  // Compare against each legal index instead of indexing in_valid[sel], so an
  // out-of-range sel simply matches nothing.
  always_comb begin
    fix_ok = 1'b0;
    for (int i = 0; i < N; i++)
      if (int'(sel) == i && in_valid[i]) fix_ok = 1'b1;
  end

  assign grant = (mode == MODE_RR) ? rr_grant : sel;
  assign gnt_v = (mode == MODE_RR) ? rr_valid : fix_ok;

  always_comb begin
    in_ready = '0;
    sel_data = '0;
    for (int i = 0; i < N; i++) begin
      if (grant == SEL_W'(i)) begin
        in_ready[i] = load_en && gnt_v && !reset;
        sel_data    = in_data[i*WIDTH +: WIDTH];
      end
    end
  end

  // ptr resets to N-1 so the first round-robin search starts at channel 0.
  always_ff @(posedge clk) begin
    if (reset) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_chan  <= '0;
      ptr       <= SEL_W'(N - 1);
    end else if (load_en) begin
      out_valid <= gnt_v;
      if (gnt_v) begin
        out_data <= sel_data;
        out_chan <= grant;
        if (mode == MODE_RR) ptr <= grant;
      end
    end
  end

endmodule

// File: tb/tb_stream_mux_rr.sv
// tb_stream_mux_rr
// Directed bench for stream_mux_rr (N=4, WIDTH=32, SEL_W=3 so sel=5 is
// expressible). A queue-free behavioural model tracks the output register
// and RR pointer from the selection rules; a negedge process compares every
// cycle, and the directed sequence adds hand-computed literal checks.
module tb_stream_mux_rr;

  logic         clk = 1'b0;
  logic         reset = 1'b1;
  logic         mode = 1'b0;
  logic [2:0]   sel = '0;
  logic [127:0] in_data;
  logic [3:0]   in_valid = '0;
  logic [3:0]   in_ready;
  logic [31:0]  out_data;
  logic [2:0]   out_chan;
  logic         out_valid;
  logic         out_ready = 1'b1;

  int checks = 0;
  int fails  = 0;
  bit chk_en = 1'b0;

  localparam logic [31:0] D0 = 32'h1000_0000;
  localparam logic [31:0] D1 = 32'h2111_1111;
  localparam logic [31:0] D2 = 32'h3222_2222;
  localparam logic [31:0] D3 = 32'h4333_3333;

  always #5 clk = ~clk;

  stream_mux_rr #(.WIDTH(32), .N(4), .SEL_W(3)) dut (
    .clk       (clk),
    .reset     (reset),
    .mode      (mode),
    .sel       (sel),
    .in_data   (in_data),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .out_data  (out_data),
    .out_chan  (out_chan),
    .out_valid (out_valid),
    .out_ready (out_ready)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Which channel the rules grant, or -1 for none.
  function automatic int exp_grant(input logic md, input logic [2:0] s,
                                   input logic [3:0] v, input int p);
    if (!md) begin
      if (s >= 3'd4) return -1;
      return v[s[1:0]] ? int'(s) : -1;
    end
    for (int k = 1; k <= 4; k++)
      if (v[(p + k) % 4]) return (p + k) % 4;
    return -1;
  endfunction

  // Model state: contents of the output register and last RR grant.
  logic        m_valid = 1'b0;
  logic [31:0] m_data  = '0;
  logic [2:0]  m_chan  = '0;
  int          m_ptr   = 3;

  always @(posedge clk) begin
    int g;
    if (reset) begin
      m_valid <= 1'b0;
      m_data  <= '0;
      m_chan  <= '0;
      m_ptr   <= 3;
    end else if (!m_valid || out_ready) begin
      g = exp_grant(mode, sel, in_valid, m_ptr);
      if (g >= 0) begin
        m_valid <= 1'b1;
        m_data  <= in_data[g*32 +: 32];
        m_chan  <= 3'(g);
        if (mode) m_ptr <= g;
      end else begin
        m_valid <= 1'b0;
      end
    end
  end

  always @(negedge clk) begin
    int g;
    logic [3:0] er;
    if (chk_en) begin
      g  = exp_grant(mode, sel, in_valid, m_ptr);
      er = (!reset && (!m_valid || out_ready) && g >= 0) ? (4'b0001 << g) : 4'b0000;
      check("model_in_ready", {28'd0, in_ready}, {28'd0, er});
      check("model_out_valid", {31'd0, out_valid}, {31'd0, m_valid});
      check("model_out_data", out_data, m_data);
      check("model_out_chan", {29'd0, out_chan}, {29'd0, m_chan});
    end
  end

  // One clock, landing just after the falling edge (after the model compare).
  task automatic tick();
    @(posedge clk);
    @(negedge clk);
    #1;
  endtask

  initial begin
    in_data = {D3, D2, D1, D0};
    tick();
    chk_en = 1'b1;
    tick();
    check("reset_out_valid", {31'd0, out_valid}, 32'd0);
    check("reset_out_data", out_data, 32'd0);
    check("reset_in_ready", {28'd0, in_ready}, 32'd0);

    // Fixed select of channel 2.
    reset = 1'b0; mode = 1'b0; sel = 3'd2; in_valid = 4'b0110; out_ready = 1'b1;
    #1 check("fixed_in_ready", {28'd0, in_ready}, 32'h4);
    tick();
    check("fixed_out_chan", {29'd0, out_chan}, 32'd2);
    check("fixed_out_data", out_data, D2);

    // Round-robin after reset: 0,1,2,3,0.
    reset = 1'b1; mode = 1'b1; in_valid = 4'b1111;
    tick();
    reset = 1'b0;
    for (int k = 0; k < 5; k++) begin
      tick();
      check("rr_seq_chan", {29'd0, out_chan}, 32'(k % 4));
      check("rr_seq_valid", {31'd0, out_valid}, 32'd1);
    end

    // Wrap-around with ptr=0: 3 then 0.
    in_valid = 4'b1001;
    tick();
    check("wrap_chan_a", {29'd0, out_chan}, 32'd3);
    tick();
    check("wrap_chan_b", {29'd0, out_chan}, 32'd0);

    // Backpressure for three cycles, then load on the draining cycle.
    in_valid = 4'b1111; out_ready = 1'b0;
    for (int k = 0; k < 3; k++) begin
      #1 check("bp_in_ready", {28'd0, in_ready}, 32'd0);
      tick();
      check("bp_out_data", out_data, D0);
      check("bp_out_valid", {31'd0, out_valid}, 32'd1);
    end
    out_ready = 1'b1;
    #1 check("bp_release_ready", {28'd0, in_ready}, 32'h2);
    tick();
    check("bp_release_chan", {29'd0, out_chan}, 32'd1);
    check("bp_release_valid", {31'd0, out_valid}, 32'd1);

    // Out-of-range fixed select drains and never grants.
    mode = 1'b0; sel = 3'd5;
    #1 check("sel5_in_ready", {28'd0, in_ready}, 32'd0);
    tick();
    check("sel5_out_valid", {31'd0, out_valid}, 32'd0);
    check("sel5_hold_data", out_data, D1);

    // Fixed transfer leaves the RR pointer at 1; next RR grant is 2.
    sel = 3'd3;
    tick();
    check("fix3_chan", {29'd0, out_chan}, 32'd3);
    mode = 1'b1;
    #1 check("ptr_kept_ready", {28'd0, in_ready}, 32'h4);
    tick();
    check("ptr_kept_chan", {29'd0, out_chan}, 32'd2);

    // Reset while holding a word with every channel valid.
    reset = 1'b1;
    #1 check("rst_in_ready", {28'd0, in_ready}, 32'd0);
    tick();
    check("rst_out_valid", {31'd0, out_valid}, 32'd0);
    check("rst_out_data", out_data, 32'd0);
    reset = 1'b0;
    #1 check("post_rst_ready", {28'd0, in_ready}, 32'h1);
    tick();
    check("post_rst_chan", {29'd0, out_chan}, 32'd0);

    in_valid = 4'b0000;
    tick();
    tick();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule

// File: doc/stream_mux_rr.md
STREAM_MUX_RR -- requirements
Module: stream_mux_rr

Interface
REQ-001 Parameter WIDTH, default 32, meaning data width of every channel in bits.
REQ-002 Parameter N, default 4, meaning number of input channels; legal range 2..16.
REQ-003 Parameter SEL_W, default clog2(N), meaning width of the select and channel-index fields.
REQ-004 Port clk  input  1  meaning the only clock; all state updates on its rising edge.
REQ-005 Port reset  input  1  meaning synchronous, active-high reset, sampled on the rising edge of clk.
REQ-006 Port mode  input  1  meaning 0 = fixed select, 1 = round-robin.
REQ-007 Port sel  input  SEL_W  meaning channel index used in fixed mode.
REQ-008 Port in_data  input  N*WIDTH  meaning packed channel data; channel i occupies bits [i*WIDTH +: WIDTH].
REQ-009 Port in_valid  input  N  meaning per-channel valid.
REQ-010 Port in_ready  output  N  meaning per-channel ready.
REQ-011 Port out_data  output  WIDTH  meaning registered output word.
REQ-012 Port out_chan  output  SEL_W  meaning registered index of the channel that supplied out_data.
REQ-013 Port out_valid  output  1  meaning output register holds a word.
REQ-014 Port out_ready  input  1  meaning downstream accepts the word this cycle.

Function
REQ-015 load_en SHALL be (!out_valid || out_ready); the output register SHALL accept a new word only when load_en=1.
REQ-016 Grant selection SHALL be combinational from the current mode, sel, in_valid and RR pointer.
REQ-017 Fixed mode: grant = sel when sel<N and in_valid[sel]=1; otherwise there SHALL be no grant (sel>=N is never an error and never grants).
REQ-018 RR mode: grant SHALL be the first i with in_valid[i]=1, searching ptr+1, ptr+2, ... and wrapping modulo N; if no channel is valid there SHALL be no grant.
REQ-019 in_ready[i] SHALL be 1 only when load_en=1 and i is the granted channel; at most one in_ready bit is high in any cycle.
REQ-020 A transfer on channel i SHALL occur when in_valid[i] && in_ready[i]; on the next edge out_data <= in_data[i], out_chan <= i, out_valid <= 1.
REQ-021 When load_en=1 and there is no grant, out_valid SHALL become 0 on the next edge; out_data and out_chan SHALL hold their values.
REQ-022 When out_valid=1 and out_ready=0, out_data, out_chan and out_valid SHALL hold, and all in_ready bits SHALL be 0.
REQ-023 Latency SHALL be 1 cycle from input transfer to out_valid; sustained throughput SHALL be 1 word per cycle while out_ready=1.
REQ-024 The RR pointer SHALL update to the granted index only on a transfer made in RR mode; fixed-mode transfers and idle cycles SHALL leave it unchanged.
REQ-025 A change of mode or sel SHALL take effect in the same cycle; a word already held in the output register is unaffected.

Reset
REQ-026 On reset: out_valid=0, out_data=0, out_chan=0, RR pointer=N-1, so channel 0 has highest RR priority after reset.
REQ-027 Reset SHALL override a transfer in the same cycle; a word held at reset is discarded and no in_ready bit is high during reset.

Structure
REQ-028 A shared package SHALL hold the mode constants MODE_FIXED=0 and MODE_RR=1 and the clog2 helper function.
REQ-029 The round-robin search SHALL live in one sub-module, rr_arbiter (inputs: req[N], ptr, en; outputs: grant index, grant_valid), instantiated once.

Verification
REQ-030 Bench SHALL cover: N=4, mode=0, sel=2, in_valid=4'b0110, out_ready=1 -> in_ready=4'b0100; next cycle out_chan=2 and out_data equals channel 2 data.
REQ-031 Bench SHALL cover: mode=1, in_valid=4'b1111 held, out_ready=1 after reset -> out_chan sequence 0,1,2,3,0 on consecutive cycles.
REQ-032 Bench SHALL cover: mode=1, in_valid=4'b1001, ptr=0 -> grant 3, then grant 0 (wrap-around).
REQ-033 Bench SHALL cover: out_valid=1, out_ready=0 for 3 cycles -> in_ready=0 throughout and out_data stable; on out_ready=1, a new word loads the same cycle it drains (no bubble).
REQ-034 Bench SHALL cover: mode=0, sel=5 with N=4 -> in_ready=0 and out_valid falls to 0 after draining.
REQ-035 Bench SHALL cover: reset asserted while out_valid=1 and in_valid=4'b1111 -> next cycle out_valid=0, in_ready=0; after release the first RR grant is channel 0.
